vj_detect_collector: RTL and testbench



---
 rtl/vj_collect_pkg.sv | 20 ++
 rtl/vj_det_fifo.sv | 48 ++++
 rtl/vj_detect_collector.sv | 139 +++++++++++++
 tb/tb_vj_detect_collector.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vj_collect_pkg.sv
// Shared types for the detection collector: output record, collector FSM states
// and the default counter width.
package vj_collect_pkg;

    localparam int CNT_W_DEF = 16;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  pyr;
    } det_rec_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        EOF
    } collect_state_e;

endpackage

// File: rtl/vj_det_fifo.sv
// First-word-fall-through synchronous FIFO of detection records; a push into a
// full FIFO succeeds when a pop happens in the same cycle.
module vj_det_fifo
    import vj_collect_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = det_rec_t
) (
    input  logic clock,
    input  logic reset_n,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     head_o,
    output logic empty_o,
    output logic full_o
);
    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    // Storage carries no reset; the head is only observed when the FIFO is non-empty.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/vj_detect_collector.sv
// Collects pipeline hits per frame into a FIFO and streams them out with a trailing
// end-of-frame record. Optional near-duplicate suppression under VJ_DEDUP_EN.
module vj_detect_collector
    import vj_collect_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int PIPE_LATENCY = 3,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEDUP_DIST   = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              frame_done,
    input  logic              hit_valid,
    input  logic [1:0][31:0]  hit_top_left,
    input  logic [3:0]        hit_pyr,
    output logic              det_valid,
    input  logic              det_ready,
    output logic [31:0]       det_x,
    output logic [31:0]       det_y,
    output logic [3:0]        det_pyr,
    output logic              det_last,
    output logic [CNT_W-1:0]  det_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow,
    output logic              protocol_err
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PIPE_LATENCY < 1 || DEDUP_DIST < 0) begin : g_bad_cfg
        $error("vj_detect_collector: illegal parameter combination");
    end

    collect_state_e          state_q, state_d;
    logic [PIPE_LATENCY-1:0] fd_dly_q;
    logic [PIPE_LATENCY:0]   fd_sh;
    logic [CNT_W-1:0]        det_cnt_q, drop_cnt_q;
    logic                    ovf_q, perr_q;
    det_rec_t                hit_rec, head;
    logic                    fifo_empty, fifo_full;
    logic                    in_collect, start, fd_arrive, pop, want, push, drop, is_dup;

    assign hit_rec.x   = hit_top_left[0];
    assign hit_rec.y   = hit_top_left[1];
    assign hit_rec.pyr = hit_pyr;

    assign in_collect = (state_q == COLLECT);
    assign start      = frame_start && (state_q == IDLE);
    assign fd_arrive  = fd_dly_q[PIPE_LATENCY-1];
    assign fd_sh      = {fd_dly_q, in_collect && frame_done};
    assign pop        = !fifo_empty && det_ready;
    assign want       = in_collect && hit_valid && !is_dup;
    assign push       = want && (!fifo_full || pop);
    assign drop       = want && fifo_full && !pop;

`ifdef VJ_DEDUP_EN
    logic     last_vld_q;
    det_rec_t last_q;
    logic [31:0] dx;

    always_comb begin
        dx     = (hit_rec.x >= last_q.x) ? hit_rec.x - last_q.x : last_q.x - hit_rec.x;
        is_dup = last_vld_q && (hit_rec.pyr == last_q.pyr) && (hit_rec.y == last_q.y)
                 && (dx <= 32'(DEDUP_DIST));
    end

    // Reference point is the last hit actually stored, so a dropped hit does not shadow later ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_vld_q <= 1'b0;
            last_q     <= '0;
        end else if (start) begin
            last_vld_q <= 1'b0;
        end else if (push) begin
            last_vld_q <= 1'b1;
            last_q     <= hit_rec;
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    vj_det_fifo #(.DEPTH(DEPTH), .T(det_rec_t)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (push),
        .data_i  (hit_rec),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_start) state_d = COLLECT;
            COLLECT: if (fd_arrive)   state_d = DRAIN;
            DRAIN:   if (fifo_empty)  state_d = EOF;
            EOF:     if (det_ready)   state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fd_dly_q   <= '0;
            det_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            fd_dly_q <= start ? '0 : fd_sh[PIPE_LATENCY-1:0];
            if (frame_start && state_q != IDLE) perr_q <= 1'b1;
            if (start) begin
                det_cnt_q  <= '0;
                drop_cnt_q <= '0;
                ovf_q      <= 1'b0;
            end else begin
                if (push && det_cnt_q != '1)  det_cnt_q  <= det_cnt_q + CNT_W'(1);
                if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                if (drop)                     ovf_q      <= 1'b1;
            end
        end
    end

    // The EOF record is only presented once the FIFO is empty, so the head mux zeroes its payload.
    assign det_valid    = !fifo_empty || (state_q == EOF);
    assign det_last     = fifo_empty && (state_q == EOF);
    assign det_x        = fifo_empty ? '0 : head.x;
    assign det_y        = fifo_empty ? '0 : head.y;
    assign det_pyr      = fifo_empty ? '0 : head.pyr;
    assign det_count    = det_cnt_q;
    assign drop_count   = drop_cnt_q;
    assign overflow     = ovf_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_vj_detect_collector.sv
// Self-checking bench for vj_detect_collector: directed frames plus randomized
// frames scored against a queue-based frame model. Dedup cases need VJ_DEDUP_EN.
module tb_vj_detect_collector;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;
    localparam int CW    = 16;
    localparam int DD    = 1;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             frame_start = 1'b0, frame_done = 1'b0, hit_valid = 1'b0, det_ready = 1'b0;
    logic [1:0][31:0] hit_top_left = '0;
    logic [3:0]       hit_pyr = '0;
    logic             det_valid, det_last, overflow, protocol_err;
    logic [31:0]      det_x, det_y;
    logic [3:0]       det_pyr;
    logic [CW-1:0]    det_count, drop_count;

    vj_detect_collector #(.DEPTH(DEPTH), .PIPE_LATENCY(LAT), .CNT_W(CW), .DEDUP_DIST(DD)) dut (
        .clock(clock), .reset_n(reset_n), .frame_start(frame_start), .frame_done(frame_done),
        .hit_valid(hit_valid), .hit_top_left(hit_top_left), .hit_pyr(hit_pyr),
        .det_valid(det_valid), .det_ready(det_ready), .det_x(det_x), .det_y(det_y),
        .det_pyr(det_pyr), .det_last(det_last), .det_count(det_count), .drop_count(drop_count),
        .overflow(overflow), .protocol_err(protocol_err)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame-level model: pending records, frame phase flags, frame_done countdown.
    typedef struct { logic [31:0] x; logic [31:0] y; logic [3:0] p; } rec_t;
    rec_t q[$];
    bit   m_coll, m_drain, m_eof, m_ovf, m_perr, m_lvld;
    int   m_timer, m_cnt, m_drop;
    rec_t m_last;

    function automatic bit m_idle();
        return !m_coll && !m_drain && !m_eof;
    endfunction

    function automatic bit m_dup(input rec_t h);
`ifdef VJ_DEDUP_EN
        longint d;
        d = longint'(h.x) - longint'(m_last.x);
        if (d < 0) d = -d;
        return m_lvld && h.p == m_last.p && h.y == m_last.y && d <= DD;
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_clear();
        q.delete();
        m_coll = 0; m_drain = 0; m_eof = 0; m_ovf = 0; m_perr = 0; m_lvld = 0;
        m_timer = 0; m_cnt = 0; m_drop = 0;
    endtask

    task automatic step();
        rec_t h;
        bit   coll0, idle0, drain_empty, pop, eofd;
        int   t0;
        @(negedge clock);
        chk("det_valid", det_valid, q.size() > 0 || m_eof);
        if (q.size() > 0) begin
            chk("det_x", det_x, q[0].x);
            chk("det_y", det_y, q[0].y);
            chk("det_pyr", det_pyr, q[0].p);
            chk("det_last", det_last, 0);
        end else if (m_eof) begin
            chk("eof_x", det_x, 0);
            chk("eof_pyr", det_pyr, 0);
            chk("eof_last", det_last, 1);
        end
        chk("det_count", det_count, m_cnt);
        chk("drop_count", drop_count, m_drop);
        chk("overflow", overflow, m_ovf);
        chk("protocol_err", protocol_err, m_perr);
        coll0 = m_coll; idle0 = m_idle(); t0 = m_timer;
        drain_empty = m_drain && q.size() == 0;
        pop  = q.size() > 0 && det_ready;
        eofd = m_eof && det_ready;
        if (pop) void'(q.pop_front());
        if (coll0 && hit_valid) begin
            h.x = hit_top_left[0]; h.y = hit_top_left[1]; h.p = hit_pyr;
            if (!m_dup(h)) begin
                if (q.size() < DEPTH) begin
                    q.push_back(h);
                    if (m_cnt < 65535) m_cnt++;
                    m_last = h; m_lvld = 1;
                end else begin
                    if (m_drop < 65535) m_drop++;
                    m_ovf = 1;
                end
            end
        end
        if (coll0 && t0 == 1) begin m_coll = 0; m_drain = 1; end
        m_timer = (t0 > 0) ? t0 - 1 : 0;
        if (coll0 && frame_done && t0 == 0) m_timer = LAT;
        if (drain_empty) begin m_drain = 0; m_eof = 1; end
        if (eofd) m_eof = 0;
        if (frame_start) begin
            if (idle0) begin
                m_coll = 1; m_cnt = 0; m_drop = 0; m_ovf = 0; m_lvld = 0; m_timer = 0;
            end else m_perr = 1;
        end
        @(posedge clock); #1;
    endtask

    task automatic drive(input bit fs, input bit fd, input bit hv, input int x, input int y,
                         input int p, input bit rdy);
        frame_start = fs; frame_done = fd; hit_valid = hv;
        hit_top_left[0] = x; hit_top_left[1] = y; hit_pyr = 4'(p); det_ready = rdy;
        step();
    endtask

    task automatic finish_frame(input bit rand_rdy);
        int n = 0;
        while (!m_idle() && n < 300) begin
            drive(0, 0, 0, 0, 0, 0, rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
            n++;
        end
        chk("frame_complete", m_idle(), 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, det_valid, 0);
        chk({tag, "_last"}, det_last, 0);
        chk({tag, "_xy"}, {det_x, det_y}, 0);
        chk({tag, "_cnts"}, {det_count, drop_count}, 0);
        chk({tag, "_flags"}, {overflow, protocol_err, det_pyr}, 0);
    endtask

    initial begin
        m_clear();
        #1 check_all_zero("reset");
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;

        // Two hits, always ready.
        drive(1, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 5, 7, 0, 1);
        drive(0, 0, 1, 9, 2, 1, 1);
        drive(0, 1, 0, 0, 0, 0, 1);
        finish_frame(0);
        chk("t1_count", det_count, 2);
        chk("t1_ovf", overflow, 0);

        // Overflow: six hits with no downstream ready.
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 10 * i, 3, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0);
        finish_frame(0);
        chk("t2_drop", drop_count, 2);
        chk("t2_ovf", overflow, 1);
        chk("t2_count", det_count, 4);

        // Hit on the delayed frame_done cycle is kept; one cycle later it is not.
        drive(1, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 40, 1, 3, 1);
        drive(0, 0, 1, 60, 1, 3, 1);
        finish_frame(0);
        chk("t3_count", det_count, 1);

        // Full FIFO with simultaneous pop and push.
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 20 * i, 5, 2, 0);
        drive(0, 0, 1, 200, 5, 2, 1);
        drive(0, 1, 0, 0, 0, 0, 1);
        finish_frame(0);
        chk("t4_drop", drop_count, 0);
        chk("t4_count", det_count, 5);

        // frame_start during DRAIN, then reset in the middle of a frame.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 1, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        finish_frame(0);
        chk("t5_perr", protocol_err, 1);
        chk("t5_count", det_count, 1);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 7, 7, 7, 0);
        drive(0, 0, 1, 17, 7, 7, 0);
        reset_n = 1'b0;
        #1 check_all_zero("midreset");
        m_clear();
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;

`ifdef VJ_DEDUP_EN
        drive(1, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 10, 4, 2, 1);
        drive(0, 0, 1, 11, 4, 2, 1);
        drive(0, 0, 1, 13, 4, 2, 1);
        drive(0, 1, 0, 0, 0, 0, 1);
        finish_frame(0);
        chk("t6_count", det_count, 2);
`endif

        // Randomized frames with backpressure, stray controls and overflow.
        for (int f = 0; f < 40; f++) begin
            int len;
            drive(1, 0, 0, 0, 0, 0, $urandom_range(0, 1) != 0);
            len = int'($urandom_range(3, 30));
            for (int c = 0; c < len; c++)
                drive($urandom_range(0, 30) == 0, 0, $urandom_range(0, 2) != 0,
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            drive(0, 1, $urandom_range(0, 1) != 0, int'($urandom_range(0, 15)), 0, 0,
                  $urandom_range(0, 1) != 0);
            for (int c = 0; c < 4; c++)
                drive(0, 0, $urandom_range(0, 1) != 0, int'($urandom_range(0, 15)), 1, 1,
                      $urandom_range(0, 1) != 0);
            finish_frame(1);
            if ($urandom_range(0, 3) == 0) drive(0, 1, 1, 3, 3, 3, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
